// File: rtl/jstk_poll_sched.sv
// jstk_poll_sched
//   Shares one PmodJSTK SPI transaction engine between two joysticks. On
//   each poll tick it polls every enabled player in turn, player 0 first.
//   For each poll it asserts data_mode, routes the engine chip select to the
//   selected device and drives that player's LED command byte. It then
//   unpacks the 40-bit result into that player's X/Y/button registers.
//   A REQ or XFER phase that stalls for TIMEOUT cycles is aborted and flagged
//   in err.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   en[1:0]             per-player poll enable
//   led0, led1          LED bits carried in each player's command byte
//   spi_cs, spi_data    engine chip select (active low) and 40-bit result
//   data_mode           transaction request to the engine
//   cmd_byte            command byte for the engine, {6'b100000, led}
//   sel                 selected player (MISO mux select)
//   cs0_n, cs1_n        per-device chip selects
//   x0,y0,btn0,x1,y1,btn1  unpacked per-player results
//   upd[1:0]            one-cycle strobe when a player's registers update
//   err[1:0]            sticky timeout flag, cleared by that player's next good poll
module jstk_poll_sched #(
  parameter int POLL_DIV = 100000,
  parameter int TIMEOUT  = 65535,
  parameter int GAP      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  en,
  input  logic [1:0]  led0,
  input  logic [1:0]  led1,
  input  logic        spi_cs,
  input  logic [39:0] spi_data,
  output logic        data_mode,
  output logic [7:0]  cmd_byte,
  output logic        sel,
  output logic        cs0_n,
  output logic        cs1_n,
  output logic [9:0]  x0,
  output logic [9:0]  y0,
  output logic [9:0]  x1,
  output logic [9:0]  y1,
  output logic [2:0]  btn0,
  output logic [2:0]  btn1,
  output logic [1:0]  upd,
  output logic [1:0]  err
);

  localparam int DIV_W = $clog2(POLL_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP + 1);

  // LATCH is the second capture cycle: the engine updates its data on the
  // negedge after cs rises, so CAPT only waits and LATCH samples.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_LATCH = 3'd4,
    ST_ABORT = 3'd5,
    ST_REL   = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              tick_s;
  logic              pending_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [GAP_W-1:0]  gap_r;
  logic              tmo_hit_s, gap_done_s;
  logic              load_s, sel_load_s, latch_s, abort_s;
  logic              sel_r, data_mode_r;
  logic [7:0]        cmd_byte_r;
  logic [9:0]        x0_r, y0_r, x1_r, y1_r;
  logic [2:0]        btn0_r, btn1_r;
  logic [1:0]        upd_r, err_r;
  logic              spi_unused_s;

  assign tick_s     = (div_cnt_r == DIV_W'(POLL_DIV - 1));
  assign tmo_hit_s  = (tmo_r == TMO_W'(TIMEOUT - 1));
  assign gap_done_s = (gap_r == GAP_W'(GAP - 1));
  // Result bits that carry no position or button information.
  assign spi_unused_s = ^{spi_data[31:26], spi_data[15:10], spi_data[7:3]};

  // Free-running poll divider.
  always_ff @(posedge clk) begin
    if (rst || tick_s) div_cnt_r <= '0;
    else               div_cnt_r <= div_cnt_r + DIV_W'(1);
  end

  // One-deep poll request; a tick arriving while one is pending is dropped.
  always_ff @(posedge clk) begin
    if (rst)                                   pending_r <= 1'b0;
    else if (state_r == ST_IDLE && pending_r)  pending_r <= 1'b0;
    else if (tick_s)                           pending_r <= 1'b1;
    else                                       pending_r <= pending_r;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (pending_r && (en != 2'b00)) state_s = ST_REQ;
                else                            state_s = ST_IDLE;
      ST_REQ:   if (!spi_cs)        state_s = ST_XFER;
                else if (tmo_hit_s) state_s = ST_ABORT;
                else                state_s = ST_REQ;
      ST_XFER:  if (spi_cs)         state_s = ST_CAPT;
                else if (tmo_hit_s) state_s = ST_ABORT;
                else                state_s = ST_XFER;
      ST_CAPT:  state_s = ST_LATCH;
      ST_LATCH: state_s = ST_REL;
      ST_ABORT: state_s = ST_REL;
      ST_REL:   if (!gap_done_s)               state_s = ST_REL;
                else if (!sel_r && en[1])      state_s = ST_REQ;
                else                           state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: player selection on REQ entry, capture and abort strobes.
  always_comb begin
    load_s     = 1'b0;
    sel_load_s = sel_r;
    if (state_r == ST_IDLE && state_s == ST_REQ) begin
      load_s     = 1'b1;
      sel_load_s = ~en[0];          // lowest enabled player
    end else if (state_r == ST_REL && state_s == ST_REQ) begin
      load_s     = 1'b1;
      sel_load_s = 1'b1;
    end else begin
      load_s     = 1'b0;
      sel_load_s = sel_r;
    end
    latch_s = (state_r == ST_LATCH);
    abort_s = (state_r == ST_ABORT);
  end

  // Per-state cycle counters: timeout in REQ/XFER, release gap in REL.
  always_ff @(posedge clk) begin
    if (rst || state_s != state_r) begin
      tmo_r <= '0;
      gap_r <= '0;
    end else begin
      tmo_r <= (state_r == ST_REQ || state_r == ST_XFER) ? tmo_r + TMO_W'(1) : '0;
      gap_r <= (state_r == ST_REL) ? gap_r + GAP_W'(1) : '0;
    end
  end

  // Selection, command byte and request line; held constant for a whole poll.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r       <= 1'b0;
      cmd_byte_r  <= 8'h80;
      data_mode_r <= 1'b0;
    end else begin
      data_mode_r <= (state_s == ST_REQ) || (state_s == ST_XFER);
      if (load_s) begin
        sel_r      <= sel_load_s;
        cmd_byte_r <= {6'b100000, (sel_load_s ? led1 : led0)};
      end
    end
  end

  // Result unpacking, update strobe and timeout flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_r <= 10'd0; y0_r <= 10'd0; btn0_r <= 3'd0;
      x1_r <= 10'd0; y1_r <= 10'd0; btn1_r <= 3'd0;
      upd_r <= 2'b00;
      err_r <= 2'b00;
    end else begin
      upd_r <= 2'b00;
      if (latch_s) begin
        if (!sel_r) begin
          x0_r   <= {spi_data[25:24], spi_data[39:32]};
          y0_r   <= {spi_data[9:8], spi_data[23:16]};
          btn0_r <= spi_data[2:0];
          upd_r  <= 2'b01;
        end else begin
          x1_r   <= {spi_data[25:24], spi_data[39:32]};
          y1_r   <= {spi_data[9:8], spi_data[23:16]};
          btn1_r <= spi_data[2:0];
          upd_r  <= 2'b10;
        end
        err_r[sel_r] <= 1'b0;
      end else if (abort_s) begin
        err_r[sel_r] <= 1'b1;
      end
    end
  end

  assign data_mode = data_mode_r;
  assign cmd_byte  = cmd_byte_r;
  assign sel       = sel_r;
  assign cs0_n     = (sel_r == 1'b0) ? spi_cs : 1'b1;
  assign cs1_n     = (sel_r == 1'b1) ? spi_cs : 1'b1;
  assign x0 = x0_r; assign y0 = y0_r; assign btn0 = btn0_r;
  assign x1 = x1_r; assign y1 = y1_r; assign btn1 = btn1_r;
  assign upd = upd_r;
  assign err = err_r;

endmodule
